// File: rtl/seq_div_8bit_if.sv
// Request/result bundle for the iterative divider: operands and start in,
// registered quotient/remainder and status flags out.
interface seq_div_8bit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             busy;
    logic             rdy;
    logic             dbz;
    logic             ovf;

    modport master (output start, a, b, input q, r, busy, rdy, dbz, ovf);
    modport slave  (input start, a, b, output q, r, busy, rdy, dbz, ovf);
endinterface

// File: rtl/seq_div_8bit.sv
// Radix-2 restoring divider: one quotient bit per cycle on magnitudes,
// followed by a single sign-fix cycle. Optional two's-complement mode.
module seq_div_8bit #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 1
) (
    input logic            clk,
    input logic            reset_n,
    seq_div_8bit_if.slave  bus
);
    localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam bit              SGN    = (SIGNED != 0);
    localparam logic [WIDTH-1:0] MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q, dvs_q, q_q, r_q;
    logic             qneg_q, rneg_q, dbz_pend_q, ovf_pend_q;
    logic             busy_q, rdy_q, dbz_q, ovf_q;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   shifted, diff;

    always_comb begin
        a_abs = bus.a;
        b_abs = bus.b;
        if (SGN && bus.a[WIDTH-1]) a_abs = -bus.a;
        if (SGN && bus.b[WIDTH-1]) b_abs = -bus.b;
        shifted = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            q_q        <= '0;
            r_q        <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            dbz_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            rdy_q      <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        busy_q     <= 1'b1;
                        rdy_q      <= 1'b0;
                        dbz_q      <= 1'b0;
                        ovf_q      <= 1'b0;
                        cnt_q      <= '0;
                        rem_q      <= '0;
                        dvs_q      <= b_abs;
                        qneg_q     <= SGN & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        rneg_q     <= SGN & bus.a[WIDTH-1];
                        dbz_pend_q <= (bus.b == '0);
                        ovf_pend_q <= SGN && (bus.a == MINNEG) && (bus.b == '1);
                        // Divide-by-zero skips the iterations; keep the raw
                        // dividend so it can be returned unmodified as r.
                        if (bus.b == '0) begin
                            dvd_q   <= bus.a;
                            state_q <= FIX;
                        end else begin
                            dvd_q   <= a_abs;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= diff[WIDTH] ? shifted : diff;
                    dvd_q <= {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH-1)) state_q <= FIX;
                end
                FIX: begin
                    if (dbz_pend_q) begin
                        q_q   <= '1;
                        r_q   <= dvd_q;
                        dbz_q <= 1'b1;
                    end else if (ovf_pend_q) begin
                        q_q   <= MINNEG;
                        r_q   <= '0;
                        ovf_q <= 1'b1;
                    end else begin
                        q_q <= qneg_q ? -dvd_q : dvd_q;
                        r_q <= rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    end
                    busy_q  <= 1'b0;
                    rdy_q   <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;
    assign bus.rdy  = rdy_q;
    assign bus.dbz  = dbz_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: doc/seq_div_8bit.md
Name: seq_div_8bit

Overview:
- Iterative radix-2 restoring divider; the inverse operation to the team's shift-add Booth multiplier.
- Same arithmetic datapath family. Accepts an 8-bit dividend and divisor on a start pulse and produces quotient and remainder after a fixed multi-cycle iteration.
- Used where a product must be undone, e.g. normalising or scaling accumulated multiplier results.

Parameters:
- WIDTH, 8, operand and result width in bits.
- SIGNED, 1, 1 = two's-complement division, 0 = unsigned division.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset. Sampled only on the rising edge of clk.
- start  input  1  request pulse. Accepted only when busy=0.
- a  input  WIDTH  dividend. Sampled on the accepting edge.
- b  input  WIDTH  divisor. Sampled on the accepting edge.
- q  output  WIDTH  quotient, registered.
- r  output  WIDTH  remainder, registered.
- busy  output  1  high while a division is in progress.
- rdy  output  1  high when q/r hold a completed result. Held until the next accepted start.
- dbz  output  1  divide-by-zero flag for the current result.
- ovf  output  1  signed overflow flag (most-negative / -1) for the current result.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE; q, r, busy, rdy, dbz, ovf all 0; iteration counter 0. Reset has priority over every other condition, including mid-division. The in-flight operation is discarded with no result.
- States:
  - IDLE: waiting for start.
  - CALC: WIDTH iterations.
  - FIX: sign correction.
  - DONE: result held.
- IDLE/DONE with start=1:
  - Latch operands.
  - Clear rdy, dbz, ovf; set busy.
  - If b==0, go to FIX; otherwise go to CALC with counter=0.
- Operand latch when SIGNED=1: store |a| and |b| as WIDTH-bit unsigned, and record sign_q = a[MSB]^b[MSB] and sign_r = a[MSB]. |most-negative| is represented as the unsigned value 2^(WIDTH-1).
- CALC, one quotient bit per cycle, MSB first:
  - Shift {partial_rem, dividend} left by 1.
  - Trial-subtract the divisor in WIDTH+1 bits.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - After WIDTH iterations (counter==WIDTH-1), go to FIX.
- FIX (one cycle), then DONE:
  - Normal case, SIGNED=1: q = sign_q ? -quot : quot; r = sign_r ? -rem : rem. Truncation is toward zero, and the remainder takes the dividend's sign.
  - Normal case, SIGNED=0: unsigned quot and rem pass through.
  - Divide by zero: q = all ones, r = a as latched (unmodified), dbz=1.
  - Overflow (SIGNED=1, a = most-negative, b = -1): q = most-negative (0x80), r=0, ovf=1.
- In DONE: busy=0, rdy=1, and q/r/dbz/ovf are stable until the next accepted start or reset.
- Latency, counted from the edge that samples start=1:
  - Normal: rdy=1 and results valid after exactly WIDTH+2 edges (10 for WIDTH=8).
  - Divide by zero: rdy=1 after 2 edges.
- start while busy=1 is ignored; the operation in progress is not disturbed.
- start held high continuously: a new operation is accepted on the first edge where busy=0. rdy is then high for exactly one cycle before being cleared by the new acceptance.
- a and b may change freely after the accepting edge.
- Internal width rule: the partial remainder is WIDTH+1 bits so the trial subtract never loses its sign bit.

Test Plan:
- SIGNED=0: a=100, b=7, start pulse -> after 10 edges rdy=1, q=14 (0x0E), r=2; busy=1 for the 9 preceding cycles.
- SIGNED=1, sign cases:
  - a=-100 (0x9C), b=7 -> q=0xF2 (-14), r=0xFE (-2).
  - a=100, b=-7 -> q=0xF2, r=0x02.
  - a=-100, b=-7 -> q=0x0E, r=0xFE.
- SIGNED=1, boundaries:
  - a=0x80, b=0xFF -> q=0x80, r=0, ovf=1.
  - a=0x80, b=0x01 -> q=0x80, r=0, ovf=0.
- Divide by zero: a=5, b=0 -> 2 edges later rdy=1, dbz=1, q=0xFF, r=0x05. A following a=9, b=3 clears dbz and gives q=3, r=0.
- Start while busy: start a=200, b=10 (unsigned), then pulse start with a=1, b=1 at edge 4 -> the second request is ignored, and the result is q=20, r=0 at edge 10.
- Reset mid-operation: reset_n=0 for one edge at iteration 5 -> next cycle all outputs 0 and state IDLE. A new start a=7, b=2 gives q=3, r=1 after 10 edges.
